// File: rtl/swap_cfg_ctrl.sv
// swap_cfg_ctrl: sequences run-time swap reconfiguration per initiator port.
// Blocks the port, drains outstanding transactions, then commits atomically.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   req_*                request handshake and fields (port/enable/source/target)
//   addr_hs_i/resp_done_i per-port issue/complete pulses for drain tracking
//   block_o              per-port issue gate
//   select_o/source_o/target_o  swap stage configuration
//   busy_o/done_o/err_o/err_code_o  status
module swap_cfg_ctrl #(
  parameter int N_INIT_PORT = 8,
  parameter int LOG_N_INIT  = 3,
  parameter int CNT_W       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [LOG_N_INIT-1:0]          req_port_i,
  input  logic                           req_enable_i,
  input  logic [LOG_N_INIT-1:0]          req_source_i,
  input  logic [LOG_N_INIT-1:0]          req_target_i,
  input  logic [N_INIT_PORT-1:0]         addr_hs_i,
  input  logic [N_INIT_PORT-1:0]         resp_done_i,
  output logic [N_INIT_PORT-1:0]         block_o,
  output logic [N_INIT_PORT-1:0]         select_o,
  output logic [N_INIT_PORT*LOG_N_INIT-1:0] source_o,
  output logic [N_INIT_PORT*LOG_N_INIT-1:0] target_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic [1:0]                     err_code_o
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    COMMIT
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt [N_INIT_PORT];
  logic [TW-1:0]          tcnt;
  logic [LOG_N_INIT-1:0]  port_q;
  logic [LOG_N_INIT-1:0]  src_q;
  logic [LOG_N_INIT-1:0]  tgt_q;
  logic                   en_q;
  logic                   bad_idx;
  logic                   drained;

  assign req_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

  // Source/target only matter when enabling; an unswap may carry junk.
  always_comb begin
    bad_idx = 1'b0;
    if (int'(req_port_i) >= N_INIT_PORT)
      bad_idx = 1'b1;
    if (req_enable_i &&
        ((int'(req_source_i) >= N_INIT_PORT) ||
         (int'(req_target_i) >= N_INIT_PORT)))
      bad_idx = 1'b1;
  end

  always_comb begin
    drained = 1'b0;
    for (int p = 0; p < N_INIT_PORT; p++) begin
      if (LOG_N_INIT'(p) == port_q)
        drained = (cnt[p] == '0);
    end
  end

  // Outstanding counters track every port in every state, including
  // illegal issues on a blocked port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < N_INIT_PORT; p++)
        cnt[p] <= '0;
    end else begin
      for (int p = 0; p < N_INIT_PORT; p++) begin
        if (addr_hs_i[p] && !resp_done_i[p]) begin
          if (cnt[p] != CMAX)
            cnt[p] <= cnt[p] + CNT_W'(1);
        end else if (resp_done_i[p] && !addr_hs_i[p]) begin
          if (cnt[p] != '0)
            cnt[p] <= cnt[p] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tcnt       <= '0;
      port_q     <= '0;
      src_q      <= '0;
      tgt_q      <= '0;
      en_q       <= 1'b0;
      block_o    <= '0;
      select_o   <= '0;
      source_o   <= '0;
      target_o   <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= 2'b00;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            err_code_o <= 2'b00;
            port_q     <= req_port_i;
            src_q      <= req_source_i;
            tgt_q      <= req_target_i;
            en_q       <= req_enable_i;
            if (bad_idx) begin
              err_o      <= 1'b1;
              err_code_o <= 2'b10;
            end else begin
              state   <= DRAIN;
              tcnt    <= '0;
              block_o <= N_INIT_PORT'(1) << req_port_i;
            end
          end
        end
        DRAIN: begin
          if (drained) begin
            state <= COMMIT;
          end else if (tcnt == TMAX) begin
            state      <= IDLE;
            block_o    <= '0;
            err_o      <= 1'b1;
            err_code_o <= 2'b01;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        COMMIT: begin
          state   <= IDLE;
          block_o <= '0;
          done_o  <= 1'b1;
          for (int p = 0; p < N_INIT_PORT; p++) begin
            if (LOG_N_INIT'(p) == port_q) begin
              select_o[p] <= en_q;
              source_o[p*LOG_N_INIT +: LOG_N_INIT] <=
                en_q ? src_q : '0;
              target_o[p*LOG_N_INIT +: LOG_N_INIT] <=
                en_q ? tgt_q : '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swap_cfg_ctrl.sv
// tb_swap_cfg_ctrl: directed and randomized checks of swap_cfg_ctrl
// against a transaction-level reference model.
module tb_swap_cfg_ctrl;

  localparam int N  = 8;
  localparam int L  = 4;
  localparam int CW = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [L-1:0]   req_port = '0;
  logic           req_enable = 1'b0;
  logic [L-1:0]   req_source = '0;
  logic [L-1:0]   req_target = '0;
  logic [N-1:0]   addr_hs = '0;
  logic [N-1:0]   resp_done = '0;
  logic [N-1:0]   block;
  logic [N-1:0]   select;
  logic [N*L-1:0] source;
  logic [N*L-1:0] target;
  logic           busy;
  logic           done;
  logic           err;
  logic [1:0]     err_code;

  swap_cfg_ctrl #(
    .N_INIT_PORT(N),
    .LOG_N_INIT (L),
    .CNT_W      (CW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_port_i  (req_port),
    .req_enable_i(req_enable),
    .req_source_i(req_source),
    .req_target_i(req_target),
    .addr_hs_i   (addr_hs),
    .resp_done_i (resp_done),
    .block_o     (block),
    .select_o    (select),
    .source_o    (source),
    .target_o    (target),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .err_code_o  (err_code)
  );

  int mc [N];
  int msel [N];
  int msrc [N];
  int mtgt [N];
  logic [N-1:0] s_hs [64];
  logic [N-1:0] s_rd [64];
  int npass = 0;
  int ntot = 0;
  int jr;

  // Outstanding-transaction model: plain saturating integer counts.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < N; p++) mc[p] = 0;
    end else begin
      for (int p = 0; p < N; p++) begin
        if (addr_hs[p] && !resp_done[p])
          mc[p] = (mc[p] + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : mc[p] + 1;
        else if (resp_done[p] && !addr_hs[p])
          mc[p] = (mc[p] > 0) ? mc[p] - 1 : 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [N-1:0] exp_sel();
    logic [N-1:0] v;
    for (int p = 0; p < N; p++) v[p] = (msel[p] != 0);
    return v;
  endfunction

  function automatic logic [N*L-1:0] exp_src();
    logic [N*L-1:0] v;
    for (int p = 0; p < N; p++) v[p*L +: L] = L'(msrc[p]);
    return v;
  endfunction

  function automatic logic [N*L-1:0] exp_tgt();
    logic [N*L-1:0] v;
    for (int p = 0; p < N; p++) v[p*L +: L] = L'(mtgt[p]);
    return v;
  endfunction

  task automatic chk_cfg(input string tag);
    chk({tag, "_sel"}, select, exp_sel());
    chk({tag, "_src"}, source, exp_src());
    chk({tag, "_tgt"}, target, exp_tgt());
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    addr_hs   = '0;
    resp_done = '0;
    req_valid = 1'b0;
  endtask

  task automatic clr_sched();
    for (int k = 0; k < 64; k++) begin
      s_hs[k] = '0;
      s_rd[k] = '0;
    end
  endtask

  // Issues one request and follows it to done/err. jend = DRAIN cycle
  // index at which the drained port was seen, -1 on timeout, 0 on reject.
  task automatic run_req(input int port, input int en, input int src,
                         input int tgt, output int jend);
    bit bad;
    logic [N-1:0] oh;
    bad = (port >= N) || (en != 0 && (src >= N || tgt >= N));
    jend = 0;
    chk("ready_pre", {busy, req_ready}, 2'b01);
    req_valid  = 1'b1;
    req_port   = L'(port);
    req_enable = (en != 0);
    req_source = L'(src);
    req_target = L'(tgt);
    tick();
    req_port   = L'($urandom);
    req_enable = 1'($urandom);
    req_source = L'($urandom);
    req_target = L'($urandom);
    if (bad) begin
      chk("rej", {busy, block, done, err, err_code},
          {1'b0, {N{1'b0}}, 1'b0, 1'b1, 2'b10});
      chk_cfg("rej");
      tick();
      chk("rej_hold", {err, err_code, req_ready}, {1'b0, 2'b10, 1'b1});
      return;
    end
    oh = N'(1) << port;
    for (int j = 1; j <= TO; j++) begin
      chk("drain", {busy, block, done, err, req_ready},
          {1'b1, oh, 3'b000});
      if (j == 1) chk("acc_code", err_code, 2'b00);
      if (mc[port] == 0) begin
        addr_hs   = s_hs[j];
        resp_done = s_rd[j];
        tick();
        chk("commit", {busy, block, done, err, req_ready},
            {1'b1, oh, 3'b000});
        tick();
        msel[port] = en;
        msrc[port] = (en != 0) ? src : 0;
        mtgt[port] = (en != 0) ? tgt : 0;
        chk("done", {busy, block, done, err, req_ready},
            {1'b0, {N{1'b0}}, 3'b101});
        chk_cfg("cfg");
        jend = j;
        tick();
        chk("done_pulse", done, 1'b0);
        return;
      end
      addr_hs   = s_hs[j];
      resp_done = s_rd[j];
      if (j == TO) begin
        tick();
        chk("tmo", {busy, block, done, err, err_code},
            {1'b0, {N{1'b0}}, 2'b01, 2'b01});
        chk_cfg("tmo");
        jend = -1;
        tick();
        chk("tmo_pulse", {err, err_code}, 3'b001);
        return;
      end
      tick();
    end
  endtask

  initial begin
    clr_sched();
    repeat (2) @(negedge clk);
    chk("rst_out", {select, source, target, block, busy, done, err, err_code},
        '0);
    chk("rst_ready", req_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Idle port commit
    run_req(2, 1, 5, 1, jr);
    chk("idle_lat", jr, 1);
    chk("idle_sel", select, 8'h04);
    chk("idle_src2", source[11:8], 4'd5);
    chk("idle_tgt2", target[11:8], 4'd1);

    // Busy port: three outstanding, completions at +5/+8/+12
    for (int k = 0; k < 3; k++) begin
      addr_hs = 8'h08;
      tick();
    end
    clr_sched();
    s_rd[5]  = 8'h08;
    s_rd[8]  = 8'h08;
    s_rd[12] = 8'h08;
    run_req(3, 1, 7, 6, jr);
    chk("busy_lat", jr, 13);
    clr_sched();

    // Drain timeout
    addr_hs = 8'h40;
    tick();
    run_req(6, 1, 3, 3, jr);
    chk("tmo_lat", jr, -1);

    // Invalid indices, then a valid request clears the code
    run_req(9, 1, 0, 0, jr);
    run_req(1, 1, 8, 2, jr);
    run_req(0, 0, 0, 0, jr);
    chk("inv_clear", jr, 1);
    run_req(5, 0, 12, 15, jr);
    chk("unswap_junk", jr, 1);

    // Counter edges: simultaneous at zero, underflow, saturation
    addr_hs   = 8'h02;
    resp_done = 8'h02;
    tick();
    resp_done = 8'h02;
    tick();
    run_req(1, 1, 4, 4, jr);
    chk("edge_zero", jr, 1);
    for (int k = 0; k < 20; k++) begin
      addr_hs = 8'h10;
      tick();
    end
    for (int k = 0; k < 15; k++) begin
      resp_done = 8'h10;
      tick();
    end
    run_req(4, 1, 2, 3, jr);
    chk("edge_sat", jr, 1);

    // Reset in the middle of a drain
    addr_hs = 8'h80;
    tick();
    req_valid  = 1'b1;
    req_port   = 4'd7;
    req_enable = 1'b1;
    req_source = 4'd6;
    req_target = 4'd6;
    tick();
    tick();
    chk("mid_busy", {busy, block}, {1'b1, 8'h80});
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {select, source, target, block, busy, done, err, err_code},
        '0);
    for (int p = 0; p < N; p++) begin
      msel[p] = 0;
      msrc[p] = 0;
      mtgt[p] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst", {req_ready, busy}, 2'b10);
    chk_cfg("post_rst");
    run_req(7, 1, 1, 1, jr);
    chk("post_rst_lat", jr, 1);

    // Randomized traffic and requests
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        addr_hs   = N'($urandom & $urandom & $urandom);
        resp_done = N'($urandom & $urandom);
        tick();
      end
      for (int k = 0; k < 64; k++) begin
        s_hs[k] = N'($urandom & $urandom & $urandom);
        s_rd[k] = N'($urandom & $urandom);
      end
      run_req(int'($urandom_range(0, 9)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), jr);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/swap_cfg_ctrl.md
Name: swap_cfg_ctrl

Overview:
- Sequences run-time reconfiguration of the crossbar region-match swap stage.
- Accepts one swap or unswap request per initiator port and blocks new transactions on that port.
- Waits until the port's outstanding transactions have drained, then commits the port's select/source/target fields atomically.
- Sits between the security/config register interface and the swap stage's select, source and target inputs.

Parameters:
- N_INIT_PORT, 8, number of initiator ports.
- LOG_N_INIT, 3, width of the port index; must satisfy 2**LOG_N_INIT >= N_INIT_PORT.
- CNT_W, 4, width of each per-port outstanding-transaction counter.
- TIMEOUT_CYC, 1024, maximum number of cycles spent in DRAIN before the request aborts.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  reconfiguration request valid.
- req_ready_o  out  1  controller can accept a request.
- req_port_i  in  LOG_N_INIT  initiator port to reconfigure.
- req_enable_i  in  1  1 = enable swap on the port, 0 = disable swap (restore passthrough).
- req_source_i  in  LOG_N_INIT  source index to program.
- req_target_i  in  LOG_N_INIT  target index to program.
- addr_hs_i  in  N_INIT_PORT  per-port pulse: address-channel handshake (new transaction issued).
- resp_done_i  in  N_INIT_PORT  per-port pulse: final response of a transaction completed.
- block_o  out  N_INIT_PORT  per-port gate; initiator must not issue new transactions while its bit is set.
- select_o  out  N_INIT_PORT  to swap stage select.
- source_o  out  N_INIT_PORT*LOG_N_INIT  to swap stage source.
- target_o  out  N_INIT_PORT*LOG_N_INIT  to swap stage target.
- busy_o  out  1  high when the FSM is not in IDLE.
- done_o  out  1  one-cycle pulse: commit applied.
- err_o  out  1  one-cycle pulse: request rejected or aborted.
- err_code_o  out  2  01 = drain timeout, 10 = invalid index; held until the next accepted request.

Behaviour:
- Reset (async, rst_n=0) clears all of:
  - outputs: select_o, source_o, target_o, block_o, busy_o, done_o, err_o, err_code_o all 0;
  - internal state: outstanding counters and timeout counter 0, FSM in IDLE.
  - req_ready_o is 1 after reset.
- Outstanding counters, per port p, updated every cycle in all states:
  - addr_hs_i[p] & ~resp_done_i[p]: increment, saturating at 2**CNT_W-1.
  - resp_done_i[p] & ~addr_hs_i[p]: decrement, holding at 0 (no underflow).
  - Both or neither set: unchanged.
- Handshake: req_ready_o = (state==IDLE). A request is accepted on a clock edge where req_valid_i & req_ready_o. Fields are captured on acceptance; later input changes are ignored.
- FSM:
  - IDLE: on accept, clear err_code_o.
    - If req_port_i >= N_INIT_PORT, or (req_enable_i and (source or target >= N_INIT_PORT)): stay in IDLE, pulse err_o next cycle, err_code_o=10, no config change.
    - Otherwise go to DRAIN, set block_o[port], clear the timeout counter.
  - DRAIN: block_o[port]=1; the timeout counter increments each cycle.
    - If cnt[port]==0, go to COMMIT. This check takes priority over timeout.
    - Else if the timeout counter reaches TIMEOUT_CYC-1, go to IDLE: clear block_o[port], pulse err_o, err_code_o=01, no config change.
  - COMMIT, exactly one cycle. On exit to IDLE:
    - enable=1: select_o[port]=1, source_o[port]=src, target_o[port]=tgt;
    - enable=0: select_o[port]=0 and both fields 0;
    - clear block_o[port], pulse done_o.
- Latency: with a request accepted at edge E and the port already drained:
  - DRAIN in cycle E..E+1, COMMIT in E+1..E+2;
  - new config, done_o=1 and req_ready_o=1 all become visible after edge E+2.
  - Minimum spacing between accepts is 3 cycles.
- Fields of other ports never change. Exactly one port is blocked at a time.
- An addr_hs_i on the blocked port (protocol violation) is still counted and extends the drain.
- Reset asserted mid-operation returns the FSM to IDLE with all outputs 0; any partial request is discarded.

Test Plan:
- Idle port: accept port=2, enable=1, src=5, tgt=1 with cnt[2]=0 -> block_o[2]=1 for 2 cycles; after edge E+2, select_o=0x04, source_o[2]=5, target_o[2]=1, done_o single pulse.
- Busy port: three addr_hs_i[3] pulses, then request on port 3, then resp_done_i[3] pulses at +5/+8/+12 -> block_o[3] held through +12; commit 2 cycles after cnt reaches 0; req_ready_o low throughout.
- Timeout: TIMEOUT_CYC=16, one outstanding transaction never completed -> after 16 DRAIN cycles err_o pulse, err_code_o=01, block_o cleared, select/source/target unchanged.
- Invalid: port=9 with N_INIT_PORT=8 -> no DRAIN, busy_o stays 0, err_o pulse, err_code_o=10; a following valid request clears err_code_o to 00 on accept.
- Counter edges: simultaneous addr_hs_i and resp_done_i at cnt=0 -> count stays 0; 20 handshakes with CNT_W=4 -> saturate at 15; resp_done_i at 0 -> stays 0.
- Mid-drain reset: assert rst_n=0 in DRAIN -> all outputs 0 immediately; after release req_ready_o=1, prior config cleared.
